// File: rtl/instr_queue.sv
// Instruction fetch queue: a circular buffer that pairs in-order memory
// read responses with the requests that produced them and presents filled
// entries to decode. Flushes squash the queue and remember how many
// responses are still in flight so they can be dropped when they return.
// DEPTH must be a power of two and at least 2.
module instr_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_pc_i,
  input  logic [31:0] req_next_pc_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_rdata_i,
  input  logic        flush_i,
  input  logic        ready_i,
  output logic        full_o,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] next_pc_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  // Pointers carry one extra MSB so that full and empty differ on wrap-around
  typedef logic [PW-1:0] ptr_t;

  ptr_t alloc_q, alloc_d;
  ptr_t fill_q,  fill_d;
  ptr_t read_q,  read_d;
  ptr_t drop_q,  drop_d;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] npc_mem   [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  ptr_t count;
  ptr_t inflight;
  ptr_t flush_drop;
  logic alloc_en;
  logic fill_en;
  logic pop_en;

  assign count      = alloc_q - read_q;
  assign inflight   = alloc_q - fill_q;
  assign flush_drop = drop_q + inflight;

  // full_o depends on registered pointers only, so fetch never sees a combinational loop
  assign full_o    = (count == ptr_t'(DEPTH));
  assign valid_o   = !rst_i && (read_q != fill_q);
  assign instr_o   = instr_mem[read_q[IW-1:0]];
  assign pc_o      = pc_mem[read_q[IW-1:0]];
  assign next_pc_o = npc_mem[read_q[IW-1:0]];

  // A request seen while full is dropped even if decode pops this cycle
  assign alloc_en = req_valid_i && !full_o && !flush_i;
  assign fill_en  = rsp_valid_i && !flush_i && (drop_q == '0) && (fill_q != alloc_q);
  assign pop_en   = valid_o && ready_i && !flush_i;

  // Next pointer and drop-counter values; flush collapses the queue onto alloc
  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    read_d  = read_q;
    drop_d  = drop_q;
    if (flush_i) begin
      fill_d = alloc_q;
      read_d = alloc_q;
      if (rsp_valid_i && (flush_drop != '0)) begin
        drop_d = flush_drop - ptr_t'(1);
      end else begin
        drop_d = flush_drop;
      end
    end else begin
      if (alloc_en) begin
        alloc_d = alloc_q + ptr_t'(1);
      end
      if (fill_en) begin
        fill_d = fill_q + ptr_t'(1);
      end
      if (pop_en) begin
        read_d = read_q + ptr_t'(1);
      end
      if (rsp_valid_i && (drop_q != '0)) begin
        drop_d = drop_q - ptr_t'(1);
      end
    end
  end

  // Pointer and drop-counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q <= '0;
      fill_q  <= '0;
      read_q  <= '0;
      drop_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      read_q  <= read_d;
      drop_q  <= drop_d;
    end
  end

  // Entry storage: addresses written on allocate, instruction word on fill
  always_ff @(posedge clk_i) begin
    if (alloc_en) begin
      pc_mem[alloc_q[IW-1:0]]  <= req_pc_i;
      npc_mem[alloc_q[IW-1:0]] <= req_next_pc_i;
    end
    if (fill_en) begin
      instr_mem[fill_q[IW-1:0]] <= rsp_rdata_i;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus a random
// phase, checked against a transactional scoreboard of pending requests,
// filled entries and responses still owed to a flush.
module tb_instr_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic [31:0] reqPc;
  logic [31:0] reqNpc;
  logic        rspValid;
  logic [31:0] rspData;
  logic        flush;
  logic        ready;
  logic        full;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] npc;

  int vecCount  = 0;
  int missCount = 0;
  bit monOn     = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } entry_t;

  entry_t reqQ[$];
  entry_t expQ[$];
  int     dropM = 0;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (reqValid),
    .req_pc_i     (reqPc),
    .req_next_pc_i(reqNpc),
    .rsp_valid_i  (rspValid),
    .rsp_rdata_i  (rspData),
    .flush_i      (flush),
    .ready_i      (ready),
    .full_o       (full),
    .valid_o      (valid),
    .instr_o      (instr),
    .pc_o         (pc),
    .next_pc_o    (npc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep();
    entry_t e;
    bit fullM;
    bit popM;
    if (rst) begin
      reqQ.delete();
      expQ.delete();
      dropM = 0;
      return;
    end
    fullM = ((reqQ.size() + expQ.size()) == DEPTH);
    popM  = (expQ.size() != 0) && ready && !flush;
    if (flush) begin
      dropM = dropM + reqQ.size();
      if (rspValid && dropM > 0) dropM--;
      reqQ.delete();
      expQ.delete();
    end else begin
      if (popM) void'(expQ.pop_front());
      if (rspValid) begin
        if (dropM > 0) begin
          dropM--;
        end else if (reqQ.size() > 0) begin
          e = reqQ.pop_front();
          e.instr = rspData;
          expQ.push_back(e);
        end
      end
      if (reqValid && !fullM) begin
        e.pc    = reqPc;
        e.npc   = reqNpc;
        e.instr = '0;
        reqQ.push_back(e);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (monOn && !rst) begin
      checkOutput("mon_valid", 32'(valid), 32'(expQ.size() != 0));
      checkOutput("mon_full", 32'(full), 32'((reqQ.size() + expQ.size()) == DEPTH));
      if (valid && ready && !flush && expQ.size() > 0) begin
        checkOutput("mon_instr", instr, expQ[0].instr);
        checkOutput("mon_pc", pc, expQ[0].pc);
        checkOutput("mon_npc", npc, expQ[0].npc);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [31:0] p, input logic s,
                               input logic [31:0] d, input logic f, input logic rd);
    reqValid = r;
    reqPc    = p;
    reqNpc   = p + 32'd4;
    rspValid = s;
    rspData  = d;
    flush    = f;
    ready    = rd;
    @(posedge clk);
    #1;
  endtask

  // Reset with every competing input asserted to exercise reset priority
  task automatic doReset(input logic s);
    rst      = 1'b1;
    reqValid = 1'b1;
    reqPc    = 32'hDEAD_0000;
    reqNpc   = 32'hDEAD_0004;
    rspValid = s;
    rspData  = 32'hBAD0_BAD0;
    flush    = 1'b1;
    ready    = 1'b1;
    #1;
    checkOutput("valid_in_reset", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    reqValid = 1'b0;
    rspValid = 1'b0;
    flush    = 1'b0;
    ready    = 1'b0;
    checkOutput("valid_after_reset", 32'(valid), 32'd0);
    checkOutput("full_after_reset", 32'(full), 32'd0);
  endtask

  initial begin
    int outst;
    logic r;
    logic s;
    logic f;

    rst = 1'b0; reqValid = 1'b0; reqPc = '0; reqNpc = '0;
    rspValid = 1'b0; rspData = '0; flush = 1'b0; ready = 1'b0;
    doReset(1'b0);
    monOn = 1'b1;

    // Basic path: request, response two cycles later, head visible next cycle
    applyStimulus(1'b1, 32'h100, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("basic_not_yet", 32'(valid), 32'd0);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("basic_still_not", 32'(valid), 32'd0);
    applyStimulus(1'b0, 0, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
    checkOutput("basic_valid", 32'(valid), 32'd1);
    checkOutput("basic_instr", instr, 32'h0000_0013);
    checkOutput("basic_pc", pc, 32'h100);
    checkOutput("basic_npc", npc, 32'h104);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("basic_popped", 32'(valid), 32'd0);

    // Fill to full, ignore an extra request, drain in order; repeat so pointers wrap
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(1'b1, k * 4, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 32'hA000_0000 + rep * 16 + k, 1'b0, 1'b0);
      end
      checkOutput("full_after_4", 32'(full), 32'd1);
      applyStimulus(1'b1, 32'h10, 1'b0, 0, 1'b0, 1'b0);
      checkOutput("full_after_5th", 32'(full), 32'd1);
      for (int k = 0; k < 4; k++) begin
        checkOutput("wrap_head_pc", pc, k * 4);
        checkOutput("wrap_head_instr", instr, 32'hA000_0000 + rep * 16 + k);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
      end
      checkOutput("wrap_empty", 32'(valid), 32'd0);
      checkOutput("wrap_not_full", 32'(full), 32'd0);
    end

    // Flush with two requests still in flight; their responses must be dropped
    applyStimulus(1'b1, 32'h300, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h304, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h308, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'hA1, 1'b0, 1'b0);
    checkOutput("pre_flush_valid", 32'(valid), 32'd1);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("flush_valid", 32'(valid), 32'd0);
    applyStimulus(1'b0, 0, 1'b1, 32'hD1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h200, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'hD2, 1'b0, 1'b0);
    checkOutput("dropped_valid", 32'(valid), 32'd0);
    applyStimulus(1'b0, 0, 1'b1, 32'hA3, 1'b0, 1'b0);
    checkOutput("post_flush_valid", 32'(valid), 32'd1);
    checkOutput("post_flush_instr", instr, 32'hA3);
    checkOutput("post_flush_pc", pc, 32'h200);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);

    // Flush coinciding with a response: only one later response is dropped
    applyStimulus(1'b1, 32'h400, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h404, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'hE1, 1'b1, 1'b0);
    checkOutput("flush_rsp_valid", 32'(valid), 32'd0);
    applyStimulus(1'b1, 32'h500, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'hE2, 1'b0, 1'b0);
    checkOutput("flush_rsp_dropped", 32'(valid), 32'd0);
    applyStimulus(1'b0, 0, 1'b1, 32'hB5, 1'b0, 1'b0);
    checkOutput("flush_rsp_instr", instr, 32'hB5);
    checkOutput("flush_rsp_pc", pc, 32'h500);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);

    // Allocate, fill and pop together with two filled entries queued
    applyStimulus(1'b1, 32'h600, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'hC0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h604, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'hC1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h608, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("simul_head_before", pc, 32'h600);
    applyStimulus(1'b1, 32'h60C, 1'b1, 32'hC2, 1'b0, 1'b1);
    checkOutput("simul_head_after", pc, 32'h604);
    checkOutput("simul_instr_after", instr, 32'hC1);
    checkOutput("simul_not_full", 32'(full), 32'd0);
    applyStimulus(1'b1, 32'h610, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("simul_count_kept", 32'(full), 32'd1);
    applyStimulus(1'b0, 0, 1'b1, 32'hC3, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'hC4, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("simul_drained", 32'(valid), 32'd0);

    // Reset mid-operation with requests outstanding and a pending drop
    applyStimulus(1'b1, 32'h700, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h704, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'hF0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h800, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h804, 1'b0, 0, 1'b0, 1'b0);
    doReset(1'b1);
    applyStimulus(1'b0, 0, 1'b1, 32'hF1, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'hF2, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'hF3, 1'b0, 1'b0);
    checkOutput("spurious_valid", 32'(valid), 32'd0);
    checkOutput("spurious_full", 32'(full), 32'd0);
    applyStimulus(1'b1, 32'h900, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 32'h99, 1'b0, 1'b0);
    checkOutput("after_reset_instr", instr, 32'h99);
    checkOutput("after_reset_pc", pc, 32'h900);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);

    // Random traffic with occasional flushes and spurious responses
    for (int i = 0; i < 300; i++) begin
      outst = dropM + reqQ.size();
      r = (outst < DEPTH) && ($urandom_range(0, 1) == 1);
      s = (outst > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 19) == 0);
      applyStimulus(r, 32'h1000 + i * 4, s, $urandom, f, $urandom_range(0, 1) == 1);
    end
    for (int k = 0; k < 12; k++) begin
      outst = dropM + reqQ.size();
      applyStimulus(1'b0, 0, outst > 0, $urandom, 1'b0, 1'b1);
    end
    checkOutput("final_empty", 32'(valid), 32'd0);
    checkOutput("final_not_full", 32'(full), 32'd0);

    monOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
